// File: rtl/vixen_uop_queue.sv
`default_nettype none
// ============================================================================
// Module   : vixen_uop_queue
// Brief    : Two-thread decoupling micro-op queue, 3-wide enqueue, 2-wide dispatch.
// Revision : 1.0 - initial release
// ============================================================================
module vixen_uop_queue #(
    parameter int DEPTH       = 16,
    parameter int UOP_W       = 64,
    parameter int AFULL_SLACK = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3*UOP_W-1:0]         enq_uops,
    input  logic [2:0]                 enq_valid,
    input  logic [5:0]                 enq_thread_id,
    input  logic [1:0]                 flush,
    output logic [2*UOP_W-1:0]         deq_uops,
    output logic [1:0]                 deq_valid,
    output logic                       deq_thread,
    input  logic [1:0]                 deq_ready,
    output logic                       stall,
    output logic [$clog2(DEPTH):0]     occ_t0,
    output logic [$clog2(DEPTH):0]     occ_t1,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] c_SLACK = CW'(AFULL_SLACK);

    logic [UOP_W-1:0] r_mem [2][DEPTH];
    logic [AW-1:0]    r_head [2];
    logic [AW-1:0]    r_tail [2];
    logic [CW-1:0]    r_count [2];
    logic             r_rr;
    logic             r_stall;
    logic             r_overflow;

    logic [CW-1:0]    w_acc [2];
    logic [1:0]       w_blocked;
    logic             w_drop;
    logic [2:0]       w_wr_en;
    logic [2:0]       w_wr_thr;
    logic [AW-1:0]    w_wr_idx [3];
    logic [1:0]       w_usable;
    logic             w_sel;
    logic             w_any;
    logic             w_pop0;
    logic             w_pop1;
    logic [CW-1:0]    w_npop;
    logic [CW-1:0]    w_deq [2];
    logic [CW-1:0]    w_next [2];
    logic             w_stall_nxt;
    logic             w_unused_tid;

    // Only bit 0 of each slot's thread id selects the thread.
    assign w_unused_tid = enq_thread_id[1] ^ enq_thread_id[3] ^ enq_thread_id[5];

    // Slots claim space in order; once a thread runs out, later slots for it drop.
    always_comb begin
        w_acc[0]  = '0;
        w_acc[1]  = '0;
        w_blocked = '0;
        w_drop    = 1'b0;
        w_wr_en   = '0;
        w_wr_thr  = '0;
        for (int i = 0; i < 3; i++) begin
            w_wr_thr[i] = enq_thread_id[2*i];
            w_wr_idx[i] = r_tail[w_wr_thr[i]] + w_acc[w_wr_thr[i]][AW-1:0];
            if (enq_valid[i] && !flush[w_wr_thr[i]]) begin
                if (!w_blocked[w_wr_thr[i]] &&
                    (w_acc[w_wr_thr[i]] < (c_DEPTH - r_count[w_wr_thr[i]]))) begin
                    w_wr_en[i]          = 1'b1;
                    w_acc[w_wr_thr[i]]  = w_acc[w_wr_thr[i]] + CW'(1);
                end else begin
                    w_blocked[w_wr_thr[i]] = 1'b1;
                    w_drop                 = 1'b1;
                end
            end
        end
    end

    assign w_usable[0] = (r_count[0] != '0) && !flush[0];
    assign w_usable[1] = (r_count[1] != '0) && !flush[1];
    assign w_sel = w_usable[r_rr]  ? r_rr  :
                   w_usable[!r_rr] ? !r_rr : r_rr;
    assign w_any = w_usable[w_sel];

    assign deq_valid[0] = w_any;
    assign deq_valid[1] = w_any && (r_count[w_sel] >= CW'(2));
    assign deq_thread   = w_sel;
    assign deq_uops     = {r_mem[w_sel][r_head[w_sel] + AW'(1)], r_mem[w_sel][r_head[w_sel]]};

    // deq_ready of 2'b10 is non-contiguous and accepts nothing.
    assign w_pop0 = deq_valid[0] & deq_ready[0];
    assign w_pop1 = w_pop0 & deq_valid[1] & deq_ready[1];
    assign w_npop = CW'(w_pop0) + CW'(w_pop1);

    always_comb begin
        for (int t = 0; t < 2; t++) begin
            w_deq[t]  = (w_sel == 1'(t)) ? w_npop : '0;
            w_next[t] = flush[t] ? '0 : (r_count[t] + w_acc[t] - w_deq[t]);
        end
        w_stall_nxt = ((c_DEPTH - w_next[0]) < c_SLACK) || ((c_DEPTH - w_next[1]) < c_SLACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 2; t++) begin
                r_head[t]  <= '0;
                r_tail[t]  <= '0;
                r_count[t] <= '0;
            end
            r_rr       <= 1'b0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            for (int t = 0; t < 2; t++) begin
                if (flush[t]) begin
                    r_head[t]  <= '0;
                    r_tail[t]  <= '0;
                    r_count[t] <= '0;
                end else begin
                    r_head[t]  <= r_head[t] + AW'(w_deq[t]);
                    r_tail[t]  <= r_tail[t] + AW'(w_acc[t]);
                    r_count[t] <= w_next[t];
                end
            end
            if (w_npop != '0) begin
                r_rr <= !r_rr;
            end
            r_stall    <= w_stall_nxt;
            r_overflow <= r_overflow | w_drop;
        end
    end

    // Storage is never reset; pointers alone define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_wr_en[i]) begin
                r_mem[w_wr_thr[i]][w_wr_idx[i]] <= enq_uops[i*UOP_W +: UOP_W];
            end
        end
    end

    assign occ_t0   = r_count[0];
    assign occ_t1   = r_count[1];
    assign stall    = r_stall;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vixen_uop_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_vixen_uop_queue
// Brief    : Directed self-checking bench for vixen_uop_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vixen_uop_queue;

    logic         clk;
    logic         rst;
    logic [191:0] enq_uops;
    logic [2:0]   enq_valid;
    logic [5:0]   enq_thread_id;
    logic [1:0]   flush;
    logic [127:0] deq_uops;
    logic [1:0]   deq_valid;
    logic         deq_thread;
    logic [1:0]   deq_ready;
    logic         stall;
    logic [4:0]   occ_t0;
    logic [4:0]   occ_t1;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    vixen_uop_queue #(.DEPTH(16), .UOP_W(64), .AFULL_SLACK(6)) dut (
        .clk(clk), .rst(rst),
        .enq_uops(enq_uops), .enq_valid(enq_valid), .enq_thread_id(enq_thread_id),
        .flush(flush),
        .deq_uops(deq_uops), .deq_valid(deq_valid), .deq_thread(deq_thread),
        .deq_ready(deq_ready),
        .stall(stall), .occ_t0(occ_t0), .occ_t1(occ_t1), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [2:0] v, input logic [5:0] tid,
                       input logic [63:0] u0, input logic [63:0] u1, input logic [63:0] u2);
        enq_valid     = v;
        enq_thread_id = tid;
        enq_uops      = {u2, u1, u0};
    endtask

    task automatic idle();
        enq(3'b000, 6'b0, 64'h0, 64'h0, 64'h0);
        flush     = 2'b00;
        deq_ready = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        chk("rst_occ_t0", 64'(occ_t0), 64'd0);
        chk("rst_occ_t1", 64'(occ_t1), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_deq_thread", 64'(deq_thread), 64'd0);

        // A->t0, B->t1, C->t0
        enq(3'b111, 6'b000100, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 64'hCCCC_0000_0000_000C);
        step();
        idle();
        chk("t1_occ_t0", 64'(occ_t0), 64'd2);
        chk("t1_occ_t1", 64'(occ_t1), 64'd1);
        chk("t1_valid", 64'(deq_valid), 64'd3);
        chk("t1_thread", 64'(deq_thread), 64'd0);
        chk("t1_slot0", deq_uops[63:0], 64'hAAAA_0000_0000_000A);
        chk("t1_slot1", deq_uops[127:64], 64'hCCCC_0000_0000_000C);
        deq_ready = 2'b11;
        step();
        chk("t1b_occ_t0", 64'(occ_t0), 64'd0);
        chk("t1b_thread", 64'(deq_thread), 64'd1);
        chk("t1b_valid", 64'(deq_valid), 64'd1);
        chk("t1b_slot0", deq_uops[63:0], 64'hBBBB_0000_0000_000B);
        step();
        chk("t1c_occ_t1", 64'(occ_t1), 64'd0);
        chk("t1c_valid", 64'(deq_valid), 64'd0);
        chk("t1c_thread", 64'(deq_thread), 64'd0);

        // D,E->t0, F->t1; then non-contiguous ready, then single pop
        enq(3'b111, 6'b010000, 64'hD, 64'hE, 64'hF);
        deq_ready = 2'b10;
        step();
        enq(3'b000, 6'b0, 64'h0, 64'h0, 64'h0);
        chk("rd_occ_t0", 64'(occ_t0), 64'd2);
        chk("rd_valid", 64'(deq_valid), 64'd3);
        step();
        chk("rd10_occ_t0", 64'(occ_t0), 64'd2);
        chk("rd10_thread_rr_held", 64'(deq_thread), 64'd0);
        deq_ready = 2'b01;
        step();
        chk("rd01_occ_t0", 64'(occ_t0), 64'd1);
        chk("rd01_thread", 64'(deq_thread), 64'd1);
        chk("rd01_slot0", deq_uops[63:0], 64'hF);
        deq_ready = 2'b11;
        step();
        chk("rd11_occ_t1", 64'(occ_t1), 64'd0);
        chk("rd11_slot0", deq_uops[63:0], 64'hE);
        step();
        chk("rd11b_occ_t0", 64'(occ_t0), 64'd0);
        idle();

        // Fill thread 0 one entry per cycle; stall from occupancy 11
        for (int i = 0; i < 16; i++) begin
            enq(3'b001, 6'b0, 64'h1000 + 64'(i), 64'h0, 64'h0);
            step();
            chk("fill_occ_t0", 64'(occ_t0), 64'(i + 1));
            chk("fill_stall", 64'(stall), (i + 1 >= 11) ? 64'd1 : 64'd0);
        end
        chk("full_no_ovf_yet", 64'(overflow), 64'd0);
        enq(3'b111, 6'b0, 64'h9, 64'h9, 64'h9);
        step();
        chk("full_occ_t0", 64'(occ_t0), 64'd16);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_slot0", deq_uops[63:0], 64'h1000);
        chk("full_slot1", deq_uops[127:64], 64'h1001);
        enq(3'b001, 6'b0, 64'h9, 64'h0, 64'h0);
        deq_ready = 2'b01;
        step();
        chk("full_enqdeq_occ", 64'(occ_t0), 64'd15);
        chk("full_enqdeq_ovf", 64'(overflow), 64'd1);
        chk("full_enqdeq_slot0", deq_uops[63:0], 64'h1001);
        enq(3'b000, 6'b0, 64'h0, 64'h0, 64'h0);
        deq_ready = 2'b11;
        for (int i = 0; i < 8; i++) step();
        chk("drain_occ", 64'(occ_t0), 64'd0);
        chk("drain_stall", 64'(stall), 64'd0);
        chk("drain_valid", 64'(deq_valid), 64'd0);
        chk("drain_ovf_sticky", 64'(overflow), 64'd1);

        // Pointer wrap: stream 15 entries through thread 0 from head 0
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 15; i++) begin
            enq(3'b001, 6'b0, 64'h2000 + 64'(i), 64'h0, 64'h0);
            deq_ready = 2'b01;
            step();
            chk("wrap_occ", 64'(occ_t0), 64'd1);
            chk("wrap_slot0", deq_uops[63:0], 64'h2000 + 64'(i));
        end
        enq(3'b011, 6'b0, 64'h200F, 64'h2010, 64'h0);
        deq_ready = 2'b01;
        step();
        idle();
        chk("wrap_hold_occ", 64'(occ_t0), 64'd2);
        chk("wrap_hold_valid", 64'(deq_valid), 64'd3);
        chk("wrap_slot0_e15", deq_uops[63:0], 64'h200F);
        chk("wrap_slot1_e0", deq_uops[127:64], 64'h2010);

        // Flush thread 1 with occ_t1 = 5 while rr prefers thread 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        enq(3'b111, 6'b010101, 64'h3000, 64'h3001, 64'h3002);
        step();
        enq(3'b111, 6'b000101, 64'h3003, 64'h3004, 64'h4000);
        step();
        enq(3'b001, 6'b0, 64'h4001, 64'h0, 64'h0);
        step();
        enq(3'b000, 6'b0, 64'h0, 64'h0, 64'h0);
        deq_ready = 2'b01;
        step();
        deq_ready = 2'b00;
        chk("fl_pre_occ_t1", 64'(occ_t1), 64'd5);
        chk("fl_pre_occ_t0", 64'(occ_t0), 64'd1);
        chk("fl_pre_thread", 64'(deq_thread), 64'd1);
        chk("fl_pre_slot0", deq_uops[63:0], 64'h3000);
        flush = 2'b10;
        enq(3'b001, 6'b000001, 64'h5555, 64'h0, 64'h0);
        #1;
        chk("fl_thread", 64'(deq_thread), 64'd0);
        chk("fl_valid", 64'(deq_valid), 64'd1);
        chk("fl_slot0", deq_uops[63:0], 64'h4001);
        step();
        idle();
        chk("fl_occ_t1", 64'(occ_t1), 64'd0);
        chk("fl_occ_t0", 64'(occ_t0), 64'd1);
        chk("fl_overflow", 64'(overflow), 64'd0);

        // Mid-stream reset with both threads busy, stall and overflow set
        for (int i = 0; i < 6; i++) begin
            enq(3'b111, 6'b010101, 64'h6000, 64'h6001, 64'h6002);
            step();
        end
        chk("pre_rst_occ_t1", 64'(occ_t1), 64'd16);
        chk("pre_rst_stall", 64'(stall), 64'd1);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        rst   = 1'b1;
        flush = 2'b01;
        enq(3'b111, 6'b000000, 64'h7, 64'h7, 64'h7);
        step();
        rst = 1'b0;
        idle();
        chk("mrst_occ_t0", 64'(occ_t0), 64'd0);
        chk("mrst_occ_t1", 64'(occ_t1), 64'd0);
        chk("mrst_stall", 64'(stall), 64'd0);
        chk("mrst_overflow", 64'(overflow), 64'd0);
        chk("mrst_valid", 64'(deq_valid), 64'd0);
        chk("mrst_thread", 64'(deq_thread), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
